nrisc_control: RTL and testbench
================================

Name: nrisc_control

Overview:
Multicycle control FSM for the nrisc 8-bit core. It sequences the program counter, instruction register, memory and register file.
- Generates the `EscPC`/`halt` pair consumed by the PC block. The PC block increments on every clock edge where `halt` is low, so this controller holds `halt` high except on the single cycle per instruction where the PC must advance or load.
- Sits between the instruction register/opcode decode and the datapath enables.

Parameters:
TRAP_VECTOR, 8'b11001000, PC value loaded on an illegal opcode when the trap feature is compiled in (equals the program memory offset).
OPCODE_W, 4, width of the opcode field, `instr[7:4]`.

Ports:
c  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
opcode  input  OPCODE_W  opcode field of the instruction register.
zero  input  1  ALU zero flag, valid in DECODE.
mem_ready  input  1  memory handshake; a transfer completes on the cycle it is sampled high.
resume  input  1  leaves HALTED.
EscPC  output  1  PC load enable (PC takes overridePC).
halt  output  1  PC hold; low means the PC advances this edge.
pc_src  output  1  overridePC mux select: 0 = jump/branch target from datapath, 1 = TRAP_VECTOR.
ir_write  output  1  instruction register load.
mem_read  output  1  memory read request.
mem_write  output  1  memory write request.
mem_addr_sel  output  1  0 = address from PC, 1 = address from ALU.
alu_op  output  3  ALU function, `opcode[2:0]`, valid in EXEC.
reg_write  output  1  register file write.
wb_sel  output  1  writeback source: 0 = ALU, 1 = memory data.
halted  output  1  high while in HALTED.
state_dbg  output  3  current state encoding.

Behaviour:
- Reset (async, `rst_n`=0): state = FETCH.
  - `halt`=1; every other output = 0.
  - Reset asserted mid-access drops `mem_read`/`mem_write` immediately.
  - The first fetch starts on the first edge after release.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, HALTED=6, TRAP=7.
- Output rule: outputs are combinational from state. Exceptions: FETCH `ir_write`/`halt` also depend on `mem_ready`; MEM `reg_write` is never asserted.
- `halt`=1 in every state and cycle except:
  - FETCH with `mem_ready`=1;
  - BRANCH;
  - TRAP.
- FETCH: `mem_read`=1, `mem_addr_sel`=0.
  - `mem_ready`=0: stay in FETCH.
  - `mem_ready`=1: `ir_write`=1, `halt`=0 (PC+1), next state DECODE.
- DECODE (1 cycle, no enables), by opcode:
  - 0 NOP → FETCH.
  - 1..7 ALU → EXEC.
  - 8 LOAD, 9 STORE → MEM.
  - A JMP → BRANCH.
  - B BEQZ → BRANCH if `zero`, else FETCH.
  - C BNEZ → BRANCH if !`zero`, else FETCH.
  - F HALT → HALTED.
  - D, E illegal → see Optional Feature.
- EXEC: `alu_op` = `opcode[2:0]` → WB.
- MEM: `mem_addr_sel`=1.
  - LOAD asserts `mem_read`; STORE asserts `mem_write`.
  - Held until `mem_ready`=1, then LOAD → WB and STORE → FETCH.
  - The request stays asserted through the ready cycle.
- WB: `reg_write`=1; `wb_sel`=1 for LOAD, 0 for ALU → FETCH.
- BRANCH: `EscPC`=1, `halt`=0, `pc_src`=0 → FETCH.
- HALTED: `halted`=1, `halt`=1. `resume`=1 → FETCH. `resume` sampled in the same cycle as HALTED entry is honoured next cycle.
- TRAP: `EscPC`=1, `halt`=0, `pc_src`=1 → FETCH.
- Invariants:
  - `EscPC`=1 only with `halt`=0.
  - `mem_read` and `mem_write` are never both 1.
  - The PC advances at most once per instruction and exactly once per completed fetch, except when it is loaded.
- Instruction latency with zero-wait memory:
  - NOP and untaken branch: 2 cycles.
  - Taken branch, STORE: 3 cycles.
  - ALU: 4 cycles.
  - LOAD: 4 cycles.
  - Each `mem_ready`-low cycle adds 1.
- `opcode` is sampled only in DECODE. Changes in other states are ignored.

Optional Feature:
Macro NRISC_CTRL_ILLEGAL_TRAP_EN.
- Defined: opcodes D/E go DECODE → TRAP, so the PC loads TRAP_VECTOR via `pc_src`=1.
- Undefined: the TRAP state is unreachable, and D/E behave as NOP (DECODE → FETCH).

Decomposition:
- Package `nrisc_pkg`: state enum/localparams, opcode localparams (OP_NOP … OP_HALT), and the default MEMORY_OFFSET/TRAP_VECTOR constant shared with the PC block.
- One natural sub-module: `nrisc_decode`, the combinational opcode → instruction-class decoder (alu/load/store/jmp/beqz/bnez/halt/illegal) used by the DECODE transition logic.

Test Plan:
- Reset then ALU opcode 3, `mem_ready`=1 always:
  - `halt` low exactly 1 cycle (FETCH).
  - States F,D,X,W.
  - `alu_op`=3.
  - `reg_write` high 1 cycle.
  - Total 4 cycles.
- LOAD with `mem_ready` low for 2 cycles in MEM: `mem_read` held 3 cycles, `mem_addr_sel`=1, then WB with `wb_sel`=1 and `reg_write`=1.
- Branch cases:
  - BEQZ, `zero`=1: BRANCH cycle with `EscPC`=1, `halt`=0, `pc_src`=0.
  - BEQZ, `zero`=0: returns to FETCH after 2 cycles; `EscPC` never high.
- HALT opcode F:
  - `halted`=1, `halt`=1 for 10 cycles with `resume`=0.
  - Pulse `resume` → FETCH next cycle, `mem_read`=1.
- Drop `rst_n` during MEM STORE: `mem_write` falls without a clock edge; after release, `state_dbg`=0 and `halt`=1.
- Opcode D:
  - With NRISC_CTRL_ILLEGAL_TRAP_EN: TRAP cycle with `EscPC`=1, `pc_src`=1.
  - Without the macro: back to FETCH in 2 cycles with no `EscPC`.

Source files
------------

// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared definitions for the nrisc 8-bit core control path.
//   - OPCODE_W        : width of the opcode field instr[7:4]
//   - MEMORY_OFFSET   : program memory base address, shared with the PC block
//   - TRAP_VECTOR     : PC value loaded on an illegal opcode; the PC block
//                       selects it when the controller raises pc_src
//   - OP_*            : opcode encodings
//   - state_t         : controller state encoding (visible on state_dbg)
//   - instr_class_t   : decoded instruction class flags
package nrisc_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [7:0] MEMORY_OFFSET = 8'b11001000;
  localparam logic [7:0] TRAP_VECTOR   = MEMORY_OFFSET;

  localparam logic [OPCODE_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_BEQZ  = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_BNEZ  = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_ILL_D = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_ILL_E = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALTED = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic jmp;
    logic beqz;
    logic bnez;
    logic halt;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/nrisc_decode.sv
// nrisc_decode: combinational opcode -> instruction class decoder.
//   opcode : in  OPCODE_W  opcode field of the instruction register
//   cls    : out           one-hot class flags (all zero for NOP)
module nrisc_decode
  import nrisc_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_t        cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_NOP:             ;
      OP_LOAD:            cls.load    = 1'b1;
      OP_STORE:           cls.store   = 1'b1;
      OP_JMP:             cls.jmp     = 1'b1;
      OP_BEQZ:            cls.beqz    = 1'b1;
      OP_BNEZ:            cls.bnez    = 1'b1;
      OP_ILL_D, OP_ILL_E: cls.illegal = 1'b1;
      OP_HALT:            cls.halt    = 1'b1;
      default:            cls.alu     = 1'b1;  // opcodes 1..7
    endcase
  end

endmodule

// File: rtl/nrisc_control.sv
// nrisc_control: multicycle control FSM for the nrisc 8-bit core.
// Sequences PC, instruction register, memory and register file.
// Build option: NRISC_CTRL_ILLEGAL_TRAP_EN routes opcodes D/E to TRAP
// (PC loads TRAP_VECTOR); otherwise they retire like NOP.
// Ports:
//   c            in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   opcode       in   opcode field, sampled only in DECODE
//   zero         in   ALU zero flag, valid in DECODE
//   mem_ready    in   memory transfer completes when sampled high
//   resume       in   leaves HALTED
//   EscPC        out  PC load enable
//   halt         out  PC hold (low = PC advances/loads this edge)
//   pc_src       out  overridePC select: 0 datapath target, 1 TRAP_VECTOR
//   ir_write     out  instruction register load
//   mem_read     out  memory read request
//   mem_write    out  memory write request
//   mem_addr_sel out  0 = PC address, 1 = ALU address
//   alu_op       out  ALU function (opcode[2:0]) in EXEC
//   reg_write    out  register file write
//   wb_sel       out  writeback source: 0 ALU, 1 memory
//   halted       out  high in HALTED
//   state_dbg    out  current state encoding
module nrisc_control
  import nrisc_pkg::*;
(
  input  logic                c,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                EscPC,
  output logic                halt,
  output logic                pc_src,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_addr_sel,
  output logic [2:0]          alu_op,
  output logic                reg_write,
  output logic                wb_sel,
  output logic                halted,
  output logic [2:0]          state_dbg
);

  state_t       state;
  instr_class_t cls;
  // Opcode-derived information captured in DECODE, so later opcode
  // changes cannot disturb an instruction already in flight.
  logic [2:0]   alu_op_q;
  logic         load_q;

  nrisc_decode u_decode (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      alu_op_q <= '0;
      load_q   <= 1'b0;
    end else begin
      case (state)
        S_FETCH:
          if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          alu_op_q <= opcode[2:0];
          load_q   <= cls.load;
          if (cls.alu)                   state <= S_EXEC;
          else if (cls.load | cls.store) state <= S_MEM;
          else if (cls.jmp)              state <= S_BRANCH;
          else if (cls.beqz)             state <= zero ? S_BRANCH : S_FETCH;
          else if (cls.bnez)             state <= zero ? S_FETCH : S_BRANCH;
          else if (cls.halt)             state <= S_HALTED;
          else if (cls.illegal) begin
`ifdef NRISC_CTRL_ILLEGAL_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_FETCH;
`endif
          end else                       state <= S_FETCH;
        end
        S_EXEC:   state <= S_WB;
        S_MEM:
          if (mem_ready) state <= load_q ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_HALTED:
          if (resume) state <= S_FETCH;
        S_TRAP:   state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode the state directly; rst_n gates them so a reset
  // asserted mid-access drops the memory request without a clock edge.
  always_comb begin
    EscPC        = 1'b0;
    halt         = 1'b1;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    alu_op       = '0;
    reg_write    = 1'b0;
    wb_sel       = 1'b0;
    halted       = 1'b0;
    state_dbg    = state;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            halt     = 1'b0;
          end
        end
        S_EXEC:   alu_op = alu_op_q;
        S_MEM: begin
          mem_addr_sel = 1'b1;
          mem_read     = load_q;
          mem_write    = !load_q;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = load_q;
        end
        S_BRANCH: begin
          EscPC = 1'b1;
          halt  = 1'b0;
        end
        S_HALTED: halted = 1'b1;
        S_TRAP: begin
          EscPC  = 1'b1;
          halt   = 1'b0;
          pc_src = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nrisc_control.sv
// tb_nrisc_control: directed self-checking bench for nrisc_control.
module tb_nrisc_control;

  logic       c = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       resume;
  logic       EscPC, halt, pc_src, ir_write, mem_read, mem_write;
  logic       mem_addr_sel, reg_write, wb_sel, halted;
  logic [2:0] alu_op;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       esc;
    logic       hlt;
    logic       psrc;
    logic       irw;
    logic       mrd;
    logic       mwr;
    logic       masel;
    logic [2:0] aop;
    logic       rw;
    logic       wbs;
    logic       hltd;
    logic [2:0] st;
  } outs_t;

  nrisc_control dut (
    .c            (c),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .resume       (resume),
    .EscPC        (EscPC),
    .halt         (halt),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr_sel (mem_addr_sel),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .state_dbg    (state_dbg)
  );

  always #5 c = ~c;

  // Idle expectation for a state: PC held, every enable low.
  function automatic outs_t base(input logic [2:0] st);
    outs_t e;
    e     = '0;
    e.hlt = 1'b1;
    e.st  = st;
    return e;
  endfunction

  function automatic outs_t fetch_exp(input logic ready);
    outs_t e;
    e     = base(3'd0);
    e.mrd = 1'b1;
    if (ready) begin
      e.hlt = 1'b0;
      e.irw = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input outs_t e);
    outs_t o;
    o = {EscPC, halt, pc_src, ir_write, mem_read, mem_write, mem_addr_sel,
         alu_op, reg_write, wb_sel, halted, state_dbg};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #2;
  endtask

  outs_t e;

  initial begin
    rst_n = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0; resume = 1'b0;
    #3;
    check("reset", base(3'd0));
    #5;
    rst_n = 1'b1;  // released between edges

    // ALU opcode 3, zero-wait memory: F,D,X,W
    mem_ready = 1'b1; opcode = 4'h3;
    #1;
    check("alu_fetch", fetch_exp(1'b1));
    tick();
    check("alu_decode", base(3'd1));
    tick();
    e = base(3'd2); e.aop = 3'd3;
    check("alu_exec", e);
    tick();
    e = base(3'd4); e.rw = 1'b1;
    check("alu_wb", e);
    tick();
    check("alu_next_fetch", fetch_exp(1'b1));

    // LOAD with two wait cycles in MEM; opcode changes there are ignored
    opcode = 4'h8;
    tick();
    check("ld_decode", base(3'd1));
    mem_ready = 1'b0;
    tick();
    opcode = 4'h9;
    #1;
    e = base(3'd3); e.mrd = 1'b1; e.masel = 1'b1;
    check("ld_mem_wait1", e);
    tick();
    check("ld_mem_wait2", e);
    mem_ready = 1'b1;
    #1;
    check("ld_mem_ready", e);
    tick();
    e = base(3'd4); e.rw = 1'b1; e.wbs = 1'b1;
    check("ld_wb", e);
    tick();
    check("ld_next_fetch", fetch_exp(1'b1));

    // BEQZ taken
    opcode = 4'hB; zero = 1'b1;
    tick();
    check("beqz_t_decode", base(3'd1));
    tick();
    e = base(3'd5); e.esc = 1'b1; e.hlt = 1'b0;
    check("beqz_t_branch", e);
    tick();
    check("beqz_t_fetch", fetch_exp(1'b1));

    // BEQZ not taken: back to FETCH after DECODE
    zero = 1'b0;
    tick();
    check("beqz_nt_decode", base(3'd1));
    tick();
    check("beqz_nt_fetch", fetch_exp(1'b1));

    // BNEZ taken with zero low
    opcode = 4'hC;
    tick();
    check("bnez_decode", base(3'd1));
    tick();
    e = base(3'd5); e.esc = 1'b1; e.hlt = 1'b0;
    check("bnez_branch", e);
    tick();
    check("bnez_fetch", fetch_exp(1'b1));

    // HALT: stays halted until resume
    opcode = 4'hF;
    tick();
    check("halt_decode", base(3'd1));
    e = base(3'd6); e.hltd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("halted_%0d", i), e);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_fetch", fetch_exp(1'b1));

    // Reset during STORE access drops mem_write asynchronously
    opcode = 4'h9;
    tick();
    check("st_decode", base(3'd1));
    mem_ready = 1'b0;
    tick();
    e = base(3'd3); e.mwr = 1'b1; e.masel = 1'b1;
    check("st_mem", e);
    rst_n = 1'b0;
    #1;
    check("st_async_reset", base(3'd0));
    #3;
    rst_n = 1'b1;
    #1;
    check("post_reset_fetch", fetch_exp(1'b0));

    // Illegal opcode D
    mem_ready = 1'b1; opcode = 4'hD;
    #1;
    check("ill_fetch", fetch_exp(1'b1));
    tick();
    check("ill_decode", base(3'd1));
    tick();
`ifdef NRISC_CTRL_ILLEGAL_TRAP_EN
    e = base(3'd7); e.esc = 1'b1; e.hlt = 1'b0; e.psrc = 1'b1;
    check("ill_trap", e);
    tick();
    check("ill_after_trap", fetch_exp(1'b1));
`else
    check("ill_as_nop", fetch_exp(1'b1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
